// File: rtl/demux_router_pkg.sv
// Shared constants and the lane index type for the 1-to-4 result router.
package demux_router_pkg;

  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  typedef enum logic [SEL_W-1:0] {
    LANE_WB  = 2'd0,
    LANE_FWD = 2'd1,
    LANE_MEM = 2'd2,
    LANE_DBG = 2'd3
  } lane_e;

endpackage

// File: rtl/demux_lane_fifo.sv
// One per-destination lane FIFO whose head word and valid flag are held in registers.
module demux_lane_fifo
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data_in,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_pop        = i_pop && r_valid;
  // A full lane may still take a word when its head leaves on the same edge.
  assign w_push       = i_push && (!w_full || w_pop);
  assign w_rd_next    = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // The next head is the slot the read pointer lands on; when that slot is
  // being written this edge the incoming word is taken directly.
  always_comb begin
    w_head_next = r_data_out;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_next)) w_head_next = i_data_in;
      else                                   w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data_in;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      r_data_out <= w_head_next;
    end
  end

  assign o_full     = w_full;
  assign o_data_out = r_data_out;
  assign o_valid    = r_valid;
  assign o_empty    = !r_valid;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-4 result router: steers each accepted word into one of four lane FIFOs.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_input,
  input  logic [SEL_W-1:0] i_selector,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_output0,
  output logic [WIDTH-1:0] o_output1,
  output logic [WIDTH-1:0] o_output2,
  output logic [WIDTH-1:0] o_output3,
  output logic             o_valid0,
  output logic             o_valid1,
  output logic             o_valid2,
  output logic             o_valid3,
  input  logic             i_ready0,
  input  logic             i_ready1,
  input  logic             i_ready2,
  input  logic             i_ready3,
  output logic             o_idle
);

  logic [LANES-1:0] w_ready;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_valid;
  logic [LANES-1:0] w_empty;
  logic [WIDTH-1:0] w_data [LANES];
  logic             w_accept;

  assign w_ready = {i_ready3, i_ready2, i_ready1, i_ready0};
  assign w_pop   = w_valid & w_ready;

  // Readiness looks only at the selected lane, never at i_in_valid.
  assign o_in_ready = !i_reset && (!w_full[i_selector] || w_pop[i_selector]);
  assign w_accept   = i_in_valid && o_in_ready;

  always_comb begin
    w_push = '0;
    case (lane_e'(i_selector))
      LANE_WB:  w_push[0] = w_accept;
      LANE_FWD: w_push[1] = w_accept;
      LANE_MEM: w_push[2] = w_accept;
      LANE_DBG: w_push[3] = w_accept;
      default:  w_push    = '0;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_push    (w_push[g]),
      .i_data_in (i_input),
      .o_full    (w_full[g]),
      .i_pop     (w_pop[g]),
      .o_data_out(w_data[g]),
      .o_valid   (w_valid[g]),
      .o_empty   (w_empty[g])
    );
  end

  assign o_output0 = w_data[0];
  assign o_output1 = w_data[1];
  assign o_output2 = w_data[2];
  assign o_output3 = w_data[3];
  assign o_valid0  = w_valid[0];
  assign o_valid1  = w_valid[1];
  assign o_valid2  = w_valid[2];
  assign o_valid3  = w_valid[3];
  // Empty flags are registered in each lane, so this follows the last edge.
  assign o_idle    = &w_empty;

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios plus random traffic against a queue model.
module tb_demux_router;
  import demux_router_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] i_input;
  logic [1:0]   i_selector;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [W-1:0] o_output0, o_output1, o_output2, o_output3;
  logic         o_valid0, o_valid1, o_valid2, o_valid3;
  logic         i_ready0, i_ready1, i_ready2, i_ready3;
  logic         o_idle;

  // clock/reset block
  always #5 clk = ~clk;

  demux_router #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_input   (i_input),
    .i_selector(i_selector),
    .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready),
    .o_output0 (o_output0),
    .o_output1 (o_output1),
    .o_output2 (o_output2),
    .o_output3 (o_output3),
    .o_valid0  (o_valid0),
    .o_valid1  (o_valid1),
    .o_valid2  (o_valid2),
    .o_valid3  (o_valid3),
    .i_ready0  (i_ready0),
    .i_ready1  (i_ready1),
    .i_ready2  (i_ready2),
    .i_ready3  (i_ready3),
    .o_idle    (o_idle)
  );

  logic [W-1:0] out_a [4];
  logic [3:0]   val_a;
  assign out_a[0] = o_output0;
  assign out_a[1] = o_output1;
  assign out_a[2] = o_output2;
  assign out_a[3] = o_output3;
  assign val_a    = {o_valid3, o_valid2, o_valid1, o_valid0};

  // scoreboard: one expected queue per lane, head at index 0
  logic [W-1:0] exp_q [4][$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver task: called just after a falling edge; checks the current state
  // against the model, lets one rising edge pass, then advances the model.
  task automatic step(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                      input logic [3:0] rdy, input logic rst);
    logic exp_rdy;
    logic all_empty;
    i_in_valid = v;
    i_selector = sel;
    i_input    = d;
    {i_ready3, i_ready2, i_ready1, i_ready0} = rdy;
    i_reset    = rst;
    #1;
    exp_rdy = !rst && ((exp_q[sel].size() < D) || (exp_q[sel].size() > 0 && rdy[sel]));
    check_eq("in_ready", W'(o_in_ready), W'(exp_rdy));
    all_empty = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check_eq($sformatf("valid%0d", n), W'(val_a[n]), W'(exp_q[n].size() > 0));
      if (exp_q[n].size() > 0) begin
        check_eq($sformatf("output%0d", n), out_a[n], exp_q[n][0]);
        all_empty = 1'b0;
      end
    end
    check_eq("idle", W'(o_idle), W'(all_empty));
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 4; n++) exp_q[n].delete();
    end else begin
      for (int n = 0; n < 4; n++)
        if (exp_q[n].size() > 0 && rdy[n]) void'(exp_q[n].pop_front());
      if (v && exp_rdy) exp_q[sel].push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    i_reset = 1'b1; i_in_valid = 1'b0; i_selector = 2'd0; i_input = '0;
    {i_ready3, i_ready2, i_ready1, i_ready0} = 4'b0000;

    // reset held for two edges
    @(negedge clk);
    check_eq("rst_in_ready_a", W'(o_in_ready), W'(0));
    @(negedge clk);
    check_eq("rst_in_ready_b", W'(o_in_ready), W'(0));
    i_reset = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      check_eq($sformatf("rst_valid%0d", n), W'(val_a[n]), W'(0));
      check_eq($sformatf("rst_output%0d", n), out_a[n], '0);
    end
    check_eq("rst_idle", W'(o_idle), W'(1));
    check_eq("rst_in_ready", W'(o_in_ready), W'(1));
    @(negedge clk);

    // single route to lane 2
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0100, 1'b0);
    check_eq("single_out2", o_output2, 32'hDEADBEEF);
    check_eq("single_valid2", W'(o_valid2), W'(1));
    step(1'b0, 2'd0, 32'h0, 4'b0100, 1'b0);
    check_eq("single_idle", W'(o_idle), W'(1));
    step(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

    // fill lane 1 and apply backpressure, then a one-cycle ready pulse
    step(1'b1, 2'd1, 32'h11, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'h22, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'h33, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'h33, 4'b0010, 1'b0);
    check_eq("bp_head", o_output1, 32'h22);
    step(1'b0, 2'd1, 32'h0, 4'b0000, 1'b0);
    step(1'b0, 2'd1, 32'h0, 4'b0010, 1'b0);
    check_eq("bp_last", o_output1, 32'h33);
    step(1'b0, 2'd1, 32'h0, 4'b0010, 1'b0);

    // lane 0 full and stalled must not block lane 3
    step(1'b1, 2'd0, 32'h1, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 32'h2, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 32'hA5, 4'b0000, 1'b0);
    check_eq("hol_out3", o_output3, 32'hA5);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd0, 32'h0, 4'b1001, 1'b0);

    // round-robin stream, all consumers ready
    for (int i = 0; i < 16; i++) step(1'b1, 2'(i % 4), W'(i), 4'hF, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);

    // reset mid-operation with a concurrent push
    step(1'b1, 2'd0, 32'hC0, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 32'hC1, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 32'hC2, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 32'hC3, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 32'hBAD, 4'b0000, 1'b1);
    check_eq("mid_rst_idle", W'(o_idle), W'(1));
    for (int k = 0; k < 2; k++) step(1'b0, 2'd1, 32'h0, 4'hF, 1'b0);

    // random traffic with occasional resets
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 99) == 0));
    for (int k = 0; k < 4; k++) step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-4 result router: the write-side counterpart of the processor's 4:1 operand select mux.
- Accepts one 32-bit word per cycle with a 2-bit destination selector and steers it into one of four per-destination lane FIFOs.
- Each lane presents its head word to a consumer (writeback, forwarding, memory, or debug path) under a valid/ready handshake.
- Decouples a single producer from four independently stalling consumers.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per lane FIFO; must be a power of two, >= 2.

Ports:
- Clock  input  1  single rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Input  input  WIDTH  word to route.
- Selector  input  2  destination lane 0..3 for Input.
- InValid  input  1  producer has a word this cycle.
- InReady  output  1  router accepts the word this cycle.
- Output0..Output3  output  WIDTH each  head word of lane n.
- Valid0..Valid3  output  1 each  lane n head word is valid.
- Ready0..Ready3  input  1 each  consumer n takes the head word this cycle.
- Idle  output  1  all four lanes empty.

Behaviour:
- Clocking and reset: one clock, Clock. Reset is synchronous and active-high.
- Outputs during and after reset: all ValidN = 0, all OutputN = 0, every lane count = 0, Idle = 1, InReady = 0 while Reset is high.
- Mid-operation reset: Reset discards all buffered words with no drain; a push or pop presented in the same cycle is ignored.
- Push condition: InValid && InReady. The word is written into lane Selector.
- InReady (combinational): !Reset && (lane[Selector] not full || (ValidSel && ReadySel)). A full lane popping in the same cycle accepts a new word.
- InReady must not depend on InValid.
- Pop condition: ValidN && ReadyN. The head advances on the next edge.
- Pops on different lanes are independent; all four may pop in one cycle.
- Latency: a word pushed at edge k appears on OutputN with ValidN = 1 after edge k. No same-cycle combinational bypass from Input to OutputN.
- Simultaneous push and pop on the same lane: count unchanged, order preserved.
  - If the lane held exactly one word, the pushed word becomes the head after the edge.
- Ordering: FIFO order within each lane. No ordering guarantee across lanes.
- Output stability: OutputN and ValidN come from registers only.
  - While ValidN = 1 and ReadyN = 0, OutputN holds stable.
- Empty lane: ValidN = 0 and OutputN holds its last value. The value is don't-care but must not be X after reset.
- Full lane: count = DEPTH. Any other lane can still accept while one lane is full; no head-of-line blocking on other selectors unless the producer stalls.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Idle: registered, equals AND of all lane-empty flags after each edge.
- InValid = 0: Selector and Input are ignored. InReady is still driven from the current Selector.

Decomposition:
- Shared package:
  - LANES = 4
  - SEL_W = 2
  - lane index enum: LANE_WB = 0, LANE_FWD = 1, LANE_MEM = 2, LANE_DBG = 3
  - default WIDTH/DEPTH constants
- Sub-module demux_lane_fifo:
  - One synchronous FIFO with ports push, data_in, full, pop, data_out, valid, empty.
  - Same Clock and Reset.
  - Instantiated four times.
- Top level contains only selector decode, InReady generation, and Idle.

Test Plan:
- Reset then idle: hold Reset 2 cycles, release -> ValidN all 0, OutputN all 0, Idle = 1, InReady = 1 with InValid = 0.
- Single route: push 0xDEADBEEF with Selector = 2, Ready2 = 1 -> one cycle later Output2 = 0xDEADBEEF, Valid2 = 1, other ValidN = 0. Next cycle Valid2 = 0, Idle = 1.
- Fill and backpressure: Ready1 = 0, push 0x11, 0x22, 0x33 to lane 1 (DEPTH = 2) -> first two accepted, InReady = 0 on the third.
  - Then pulse Ready1 for one cycle: the 0x33 push is accepted in that cycle, and Output1 sequence is 0x11, 0x22, 0x33.
- No head-of-line blocking: lane 0 full with Ready0 = 0, push 0xA5 to Selector = 3 -> accepted immediately, Output3 = 0xA5 next cycle.
- Round-robin stream: 16 words, Selector = i mod 4, data = i, all Ready = 1 -> every push accepted. Each lane emits i, i+4, i+8, i+12 in order with 1-cycle latency.
- Reset mid-operation: lanes 0 and 2 each hold 2 words, assert Reset for 1 cycle together with a push -> all ValidN = 0, Idle = 1, the pushed word never appears.
